accum16_unsigned_frame: RTL and testbench
=========================================

// Module: accum16_unsigned_frame
// PURPOSE
//   Frame accumulator directly upstream of the 11-bit RNE rounding stage.
//   Sums 2^N_LOG2 unsigned IN_W-bit samples into one OUT_W-bit result (27 bits at defaults).
//   The result feeds the rounder's 27-bit input_data.
//   Valid/ready on both sides. Output is held stable until consumed.
// PARAMETERS
//   IN_W    23  sample width (unsigned)
//   N_LOG2  4   log2 of samples per frame (16 at default)
//   OUT_W   IN_W+N_LOG2 (27)  sum width; derived, never overridden
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      sample valid
//   in_ready   out  1      sample accepted when in_valid && in_ready
//   in_data    in   IN_W   unsigned sample
//   out_valid  out  1      frame sum valid
//   out_ready  in   1      consumer accepts when out_valid && out_ready
//   out_data   out  OUT_W  frame sum, registered
//   flush      in   1      ACCUM_FLUSH_EN only: close frame early
// BEHAVIOUR
//   Reset (async assert, sync deassert upstream):
//     - state=ACCUM, count=0, acc=0, out_valid=0, out_data=0.
//     - Reset mid-frame discards the partial sum and any held result.
//   State ACCUM:
//     - in_ready=1.
//     - Each accepted sample: acc += in_data; count += 1.
//     - On the accepted sample with count==2^N_LOG2-1: out_data <= acc+in_data; acc<=0; count<=0.
//       Same edge: out_valid<=1, state->HOLD. Latency is 1 cycle from the last beat to out_valid.
//   State HOLD:
//     - out_valid=1; out_data frozen.
//     - in_ready = out_ready (combinational); no other comb in->out paths.
//     - out_ready=1: out_valid<=0, state->ACCUM.
//       If in_valid is also high, that sample is accepted as sample 0 of the next frame:
//       acc<=in_data, count<=1. No bubble.
//     - out_ready=0: no samples accepted; acc and count unchanged.
//   Arithmetic:
//     - Zero-extended unsigned adds, OUT_W bits wide. Overflow is impossible by width.
//     - Max sum at defaults = 16*0x7FFFFF = 0x7FFFFF0.
//   count is N_LOG2 bits. It wraps 2^N_LOG2-1 -> 0 only at frame close.
//   in_valid=0 cycles within a frame are idle: state, acc and count are held.
// CONFIGURATION
//   Macro ACCUM_FLUSH_EN.
//   Defined:
//     - flush port exists. flush is sampled only in ACCUM.
//     - flush=1 with an accepted sample: that sample is included, then the frame closes as on the last sample.
//     - flush=1 with no accepted sample and count>0: out_data<=acc, frame closes.
//     - flush=1 with count==0 and no sample: ignored, no empty frame is emitted.
//     - In HOLD, flush is ignored.
//   Undefined:
//     - No flush port. Frames are always exactly 2^N_LOG2 samples.
// TESTING
//   1. 16 beats in_data=1, out_ready=1 -> out_valid 1 cycle after beat 16; out_data=27'd16.
//   2. 16 beats in_data=0x7FFFFF -> out_data=0x7FFFFF0, no wrap. Then 16 beats of 0 -> out_data=0.
//   3. Backpressure: frame done, out_ready=0 for 5 cycles, in_valid=1
//      -> in_ready=0; out_data stable; no sample lost. Release -> next frame sums correctly.
//   4. Handoff: in HOLD, out_ready=1 and in_valid=1 with data 7, then 15 beats of 1
//      -> next out_data=22; no idle cycle between frames.
//   5. Reset mid-frame after 7 beats of 100 (rst_n low 1 cycle)
//      -> outputs 0 immediately; then 16 beats of 2 -> out_data=32.
//   6. ACCUM_FLUSH_EN: 3 beats of 5, then flush alone -> out_data=15.
//      flush with count==0 -> no out_valid.

Source files
------------

// File: rtl/accum16_unsigned_frame.sv
// Frame accumulator: sums 2^N_LOG2 unsigned samples into one registered OUT_W-bit result.
// Optional early frame close via the flush port when ACCUM_FLUSH_EN is defined.
module accum16_unsigned_frame #(
  parameter int unsigned IN_W   = 23,
  parameter int unsigned N_LOG2 = 4,
  localparam int unsigned OUT_W = IN_W + N_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ACCUM_FLUSH_EN
  input  logic             flush,
`endif
  output logic [OUT_W-1:0] out_data
);

  typedef enum logic [0:0] {
    S_ACCUM = 1'b0,
    S_HOLD  = 1'b1
  } state_e;

  localparam logic [N_LOG2-1:0] CNT_MAX = {N_LOG2{1'b1}};

  state_e             state_q, state_d;
  logic [N_LOG2-1:0]  count_q, count_d;
  logic [OUT_W-1:0]   acc_q, acc_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic [OUT_W-1:0]   sum_c;
  logic               last_c;
  logic               flush_c;

`ifdef ACCUM_FLUSH_EN
  assign flush_c = flush;
`else
  assign flush_c = 1'b0;
`endif

  // While holding a result, a new sample can only enter on the same edge the result leaves.
  assign in_ready  = (state_q == S_HOLD) ? out_ready : 1'b1;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  assign sum_c  = acc_q + OUT_W'(in_data);
  assign last_c = (count_q == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_ACCUM;
      count_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    case (state_q)
      S_ACCUM: begin
        if (in_valid) begin
          if (last_c || flush_c) begin
            out_data_d  = sum_c;
            out_valid_d = 1'b1;
            acc_d       = '0;
            count_d     = '0;
            state_d     = S_HOLD;
          end else begin
            acc_d   = sum_c;
            count_d = count_q + N_LOG2'(1);
          end
        end else if (flush_c && (count_q != '0)) begin
          // Early close of a partial frame; an empty frame is never emitted.
          out_data_d  = acc_q;
          out_valid_d = 1'b1;
          acc_d       = '0;
          count_d     = '0;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_ACCUM;
          if (in_valid) begin
            acc_d   = OUT_W'(in_data);
            count_d = N_LOG2'(1);
          end
        end
      end
      default: begin
        state_d = S_ACCUM;
      end
    endcase
  end

endmodule

// File: tb/tb_accum16_unsigned_frame.sv
// Scoreboard bench for accum16_unsigned_frame: directed frames, expected sums queued, monitor compares.
// Define ACCUM_FLUSH_EN for both DUT and bench to exercise the flush path.
module tb_accum16_unsigned_frame;

  localparam int unsigned IN_W  = 23;
  localparam int unsigned OUT_W = 27;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef ACCUM_FLUSH_EN
  logic             flush;
`endif

  int n_cmp;
  int n_fail;
  logic [OUT_W-1:0] exp_q[$];

  accum16_unsigned_frame #(.IN_W(IN_W), .N_LOG2(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ACCUM_FLUSH_EN
    .flush     (flush),
`endif
    .out_data  (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every completed output transfer is compared against the oldest expected sum.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: got 0x%0h, expected no output at %0t", out_data, $time);
      end else begin
        check("frame_sum", out_data, exp_q.pop_front());
      end
    end
  end

  // One sample, held until accepted; returns #1 after the accepting edge.
  task automatic beat(input logic [IN_W-1:0] d);
    logic acc;
    int   guard;
    in_valid = 1'b1;
    in_data  = d;
    guard    = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL beat_timeout: sample 0x%0h not accepted, expected acceptance", d);
    end
  endtask

  task automatic beats(input int n, input logic [IN_W-1:0] d);
    for (int i = 0; i < n; i++) beat(d);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
`ifdef ACCUM_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", OUT_W'(out_valid), 0);
    check("reset_out_data", out_data, 0);
    check("reset_in_ready", OUT_W'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: sixteen ones, result visible one cycle after the last beat
    exp_q.push_back(27'd16);
    beats(15, 23'd1);
    check("pre_close_valid", OUT_W'(out_valid), 0);
    beat(23'd1);
    check("latency_valid", OUT_W'(out_valid), 1);
    check("latency_data", out_data, 27'd16);
    idle(2);
    drain();

    // 2: maximum samples, no wrap; then an all-zero frame
    exp_q.push_back(27'h7FFFFF0);
    beats(16, 23'h7FFFFF);
    exp_q.push_back(27'd0);
    beats(16, 23'd0);
    idle(2);
    drain();

    // 3: backpressure with a sample waiting
    out_ready = 1'b0;
    exp_q.push_back(27'd144);
    beats(16, 23'd9);
    in_valid = 1'b1;
    in_data  = 23'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", OUT_W'(in_ready), 0);
      check("bp_out_valid", OUT_W'(out_valid), 1);
      check("bp_out_data", out_data, 27'd144);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    exp_q.push_back(27'd48);
    beats(16, 23'd3);
    idle(2);
    drain();

    // 4: handoff in HOLD without a bubble
    exp_q.push_back(27'd16);
    beats(16, 23'd1);
    in_valid = 1'b1;
    in_data  = 23'd7;
    @(negedge clk);
    check("handoff_out_valid", OUT_W'(out_valid), 1);
    check("handoff_in_ready", OUT_W'(in_ready), 1);
    @(posedge clk);
    #1;
    check("handoff_released", OUT_W'(out_valid), 0);
    exp_q.push_back(27'd22);
    beats(15, 23'd1);
    idle(2);
    drain();

    // 5: reset mid-frame discards the partial sum
    beats(7, 23'd100);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midreset_out_valid", OUT_W'(out_valid), 0);
    check("midreset_out_data", out_data, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back(27'd32);
    beats(16, 23'd2);
    idle(2);
    drain();

`ifdef ACCUM_FLUSH_EN
    // 6: flush a partial frame, then flush with nothing accumulated
    exp_q.push_back(27'd15);
    beats(3, 23'd5);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_valid", OUT_W'(out_valid), 1);
    check("flush_data", out_data, 27'd15);
    idle(2);
    drain();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("empty_flush_valid", OUT_W'(out_valid), 0);
      @(posedge clk);
      #1;
    end
`endif

    idle(4);
    check("outstanding", OUT_W'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
